// File: rtl/bus_regfile.sv
// Datapath register file: NREG general registers (top one is the PC) plus G,
// a source-select bus mux with optional registered bus stage, and a sticky illegal-select flag.
module bus_regfile #(
  parameter int unsigned WORD    = 16,
  parameter int unsigned NREG    = 8,
  parameter int unsigned SELW    = 4,
  parameter int unsigned REG_OUT = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WORD-1:0]            din,
  input  logic [WORD-1:0]            alu_result,
  input  logic [SELW-1:0]            select,
  input  logic [NREG-1:0]            rin,
  input  logic                       gin,
  input  logic                       incr_pc,
  output logic [WORD-1:0]            bus,
  output logic [WORD*(NREG+1)-1:0]   regs_flat,
  output logic                       sel_err
);

  localparam int unsigned PC     = NREG - 1;
  localparam int unsigned SEL_G  = NREG;
  localparam int unsigned SEL_DIN = NREG + 1;
  localparam int unsigned SEL_BAD = NREG + 2;

  logic [WORD-1:0] regs [NREG];
  logic [WORD-1:0] g;
  logic [WORD-1:0] mux_val;

  // Source mux; unused codes read as zero.
  always_comb begin
    mux_val = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (select == SELW'(i)) mux_val = regs[i];
    end
    if (select == SELW'(SEL_G))   mux_val = g;
    if (select == SELW'(SEL_DIN)) mux_val = din;
  end

  if (REG_OUT != 0) begin : g_bus_reg
    logic [WORD-1:0] bus_q;
    always_ff @(posedge clk) begin
      if (rst) bus_q <= '0;
      else     bus_q <= mux_val;
    end
    assign bus = bus_q;
  end else begin : g_bus_comb
    assign bus = mux_val;
  end

  // Registers load from the bus port; on the PC a bus write beats the increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
      g <= '0;
    end else begin
      for (int unsigned i = 0; i < PC; i++) begin
        if (rin[i]) regs[i] <= bus;
      end
      if (rin[PC])      regs[PC] <= bus;
      else if (incr_pc) regs[PC] <= regs[PC] + WORD'(1);
      if (gin) g <= alu_result;
    end
  end

  // Widened compare so the illegal threshold may equal 2**SELW.
  always_ff @(posedge clk) begin
    if (rst) sel_err <= 1'b0;
    else if ({1'b0, select} >= (SELW+1)'(SEL_BAD)) sel_err <= 1'b1;
  end

  always_comb begin
    regs_flat = '0;
    for (int unsigned i = 0; i < NREG; i++) regs_flat[i*WORD +: WORD] = regs[i];
    regs_flat[NREG*WORD +: WORD] = g;
  end

endmodule

// File: tb/tb_bus_regfile.sv
// Directed bench for bus_regfile: one combinational-bus instance and one
// registered-bus instance driven from shared inputs.
module tb_bus_regfile;
  localparam int unsigned WORD = 16;
  localparam int unsigned NREG = 8;
  localparam int unsigned SELW = 4;
  localparam int unsigned FW   = WORD * (NREG + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic [WORD-1:0] din, alu_result;
  logic [SELW-1:0] select;
  logic [NREG-1:0] rin;
  logic            gin, incr_pc;
  logic [WORD-1:0] bus0, bus1;
  logic [FW-1:0]   rf0, rf1;
  logic            err0, err1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bus_regfile #(.WORD(WORD), .NREG(NREG), .SELW(SELW), .REG_OUT(0)) dut0 (
    .clk(clk), .rst(rst), .din(din), .alu_result(alu_result), .select(select),
    .rin(rin), .gin(gin), .incr_pc(incr_pc), .bus(bus0), .regs_flat(rf0), .sel_err(err0));

  bus_regfile #(.WORD(WORD), .NREG(NREG), .SELW(SELW), .REG_OUT(1)) dut1 (
    .clk(clk), .rst(rst), .din(din), .alu_result(alu_result), .select(select),
    .rin(rin), .gin(gin), .incr_pc(incr_pc), .bus(bus1), .regs_flat(rf1), .sel_err(err1));

  task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WORD-1:0] r0(input int unsigned i);
    return rf0[i*WORD +: WORD];
  endfunction

  initial begin
    rst = 1'b1; din = '0; alu_result = '0; select = '0; rin = '0; gin = 1'b0; incr_pc = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    // T1 reset
    check("t1_bus0", FW'(bus0), FW'(0));
    check("t1_regs0", rf0, '0);
    check("t1_err0", FW'(err0), FW'(0));
    check("t1_bus1", FW'(bus1), FW'(0));
    check("t1_regs1", rf1, '0);

    // T2 load R0 from din, read back
    din = 16'h1234; select = 4'd9; rin = 8'h01;
    #1 check("t2_bus_din", FW'(bus0), FW'(16'h1234));
    tick();
    rin = '0; select = 4'd0;
    #1 check("t2_bus_r0", FW'(bus0), FW'(16'h1234));
    check("t2_r0", FW'(r0(0)), FW'(16'h1234));
    check("t2_r1", FW'(r0(1)), FW'(0));

    // T3 broadcast and G
    select = 4'd9; din = 16'hA5A5; rin = 8'hFF;
    tick();
    rin = '0;
    for (int i = 0; i < NREG; i++) check($sformatf("t3_r%0d", i), FW'(r0(i)), FW'(16'hA5A5));
    gin = 1'b1; alu_result = 16'h0F0F;
    tick();
    gin = 1'b0; select = 4'd8;
    #1 check("t3_bus_g", FW'(bus0), FW'(16'h0F0F));
    check("t3_g", FW'(r0(NREG)), FW'(16'h0F0F));

    // Self reload of R2 through the bus
    select = 4'd2; rin = 8'h04;
    tick();
    rin = '0;
    check("self_r2", FW'(r0(2)), FW'(16'hA5A5));

    // T4 PC wrap and write priority
    select = 4'd9; din = 16'hFFFF; rin = 8'h80;
    tick();
    rin = '0; incr_pc = 1'b1;
    check("t4_r7_ffff", FW'(r0(7)), FW'(16'hFFFF));
    tick();
    check("t4_wrap", FW'(r0(7)), FW'(16'h0000));
    tick();
    check("t4_inc1", FW'(r0(7)), FW'(16'h0001));
    din = 16'h0040; select = 4'd9; rin = 8'h80; incr_pc = 1'b1;
    tick();
    rin = '0; incr_pc = 1'b0;
    check("t4_write_wins", FW'(r0(7)), FW'(16'h0040));

    // T5 illegal select is sticky
    check("t5_err_pre", FW'(err0), FW'(0));
    select = 4'd12;
    #1 check("t5_bus_zero", FW'(bus0), FW'(0));
    tick();
    check("t5_err_set", FW'(err0), FW'(1));
    check("t5_g_kept", FW'(r0(NREG)), FW'(16'h0F0F));
    for (int s = 0; s <= 9; s++) begin
      select = SELW'(s);
      tick();
      check($sformatf("t5_sticky_%0d", s), FW'(err0), FW'(1));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_err_clr", FW'(err0), FW'(0));
    check("t5_regs_clr", rf0, '0);

    // T6 registered bus: load R3 through bus_q, then check one-cycle latency
    select = 4'd9; din = 16'h0033;
    tick();
    select = 4'd0; rin = 8'h08;
    check("t6_busq_din", FW'(bus1), FW'(16'h0033));
    tick();
    rin = '0;
    check("t6_r3", FW'(rf1[3*WORD +: WORD]), FW'(16'h0033));
    check("t6_bus_r0", FW'(bus1), FW'(0));
    select = 4'd3;
    #1 check("t6_not_before", FW'(bus1), FW'(0));
    tick();
    check("t6_latency", FW'(bus1), FW'(16'h0033));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_busq", FW'(bus1), FW'(0));
    check("t6_rst_regs", rf1, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
